// File: rtl/bayer_stream_tx_pkg.sv
// bayer_stream_tx_pkg: shared colour codes, field widths and FSM encodings for the Bayer frame source
package bayer_stream_tx_pkg;
   localparam int COLOR_BIT_CNT = 2;
   localparam int MODE_BIT_CNT  = 3;
   localparam int COLOR_DEPTH   = 8;
   typedef enum logic [COLOR_BIT_CNT-1:0] {
      VOID  = 2'd0,
      RED   = 2'd1,
      GREEN = 2'd2,
      BLUE  = 2'd3
   } color_e;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      STREAM   = 2'd1,
      WAIT_FIN = 2'd2
   } state_e;
   function automatic color_e bayer_color(input logic row_odd, input logic col_odd);
      return row_odd ? (col_odd ? BLUE : GREEN) : (col_odd ? GREEN : RED);
   endfunction
endpackage

// File: rtl/bayer_rd_skid.sv
// bayer_rd_skid: one-entry skid absorbing the 1-cycle SRAM read latency against sink stall
module bayer_rd_skid #(
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ren_i,
   input  logic             stall_i,
   input  logic [DEPTH-1:0] rdata_i,
   output logic             emit_o,
   output logic [DEPTH-1:0] data_o
);
   logic             rvld_q, hold_q;
   logic [DEPTH-1:0] skid_q;

   // reads stop while stalled, so a full skid never meets fresh read data
   assign emit_o = !stall_i && (rvld_q || hold_q);
   assign data_o = hold_q ? skid_q : rdata_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvld_q <= 1'b0;
         hold_q <= 1'b0;
         skid_q <= '0;
      end else begin
         rvld_q <= ren_i;
         hold_q <= stall_i && (hold_q || rvld_q);
         if (stall_i && rvld_q && !hold_q) skid_q <= rdata_i;
      end
   end
endmodule

// File: rtl/bayer_stream_tx.sv
// bayer_stream_tx: streams a raw RGGB frame from SRAM in raster order, then waits for the ISP finish
module bayer_stream_tx
   import bayer_stream_tx_pkg::*;
#(
   parameter int COLS_LOG2 = 2,
   parameter int ROWS_LOG2 = 2,
   parameter int DEPTH     = COLOR_DEPTH,
   parameter int MODE_W    = MODE_BIT_CNT,
   parameter int TIMEOUT   = 1024
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [MODE_W-1:0]              mode_sel,
   input  logic                           stall,
   output logic                           mem_ren,
   output logic [COLS_LOG2+ROWS_LOG2-1:0] mem_addr,
   input  logic [DEPTH-1:0]               mem_rdata,
   output logic [DEPTH-1:0]               pixel_out,
   output logic                           valid_out,
   output logic [COLOR_BIT_CNT-1:0]       color_out,
   output logic                           last_col_out,
   output logic                           last_pic_out,
   output logic [MODE_W-1:0]              mode_out,
   input  logic                           finish_in,
   output logic                           busy,
   output logic                           done,
   output logic                           timeout_err
);
   localparam int AW = COLS_LOG2 + ROWS_LOG2;
   localparam int TW = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [AW:0]       rd_cnt_q, rd_cnt_d;
   logic [AW-1:0]     out_cnt_q, out_cnt_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic              err_q, err_d, done_q, done_d;
   logic              valid_q, last_col_q, last_pic_q;
   logic [DEPTH-1:0]  pixel_q;
   color_e            color_q;
   logic              emit;
   logic [DEPTH-1:0]  emit_data;

   // rd_cnt MSB marks every address of the frame as issued
   assign mem_ren  = state_q == STREAM && !stall && !rd_cnt_q[AW];
   assign mem_addr = rd_cnt_q[AW-1:0];

   bayer_rd_skid #(.DEPTH(DEPTH)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .ren_i   (mem_ren),
      .stall_i (stall),
      .rdata_i (mem_rdata),
      .emit_o  (emit),
      .data_o  (emit_data)
   );

   always_comb begin
      state_d   = state_q;
      rd_cnt_d  = mem_ren ? rd_cnt_q + (AW+1)'(1) : rd_cnt_q;
      out_cnt_d = emit ? out_cnt_q + AW'(1) : out_cnt_q;
      tmr_d     = tmr_q;
      mode_d    = mode_q;
      err_d     = err_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: if (start) begin
            state_d   = STREAM;
            rd_cnt_d  = '0;
            out_cnt_d = '0;
            mode_d    = mode_sel;
            err_d     = 1'b0;
         end
         STREAM: if (emit && &out_cnt_q) begin
            state_d = WAIT_FIN;
            tmr_d   = '0;
         end
         WAIT_FIN: if (finish_in) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else if (tmr_q >= TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
         end else begin
            tmr_d = tmr_q + TW'(tmr_q != TW'(TIMEOUT));
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rd_cnt_q   <= '0;
         out_cnt_q  <= '0;
         tmr_q      <= '0;
         mode_q     <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
         pixel_q    <= '0;
         color_q    <= VOID;
         last_col_q <= 1'b0;
         last_pic_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         out_cnt_q  <= out_cnt_d;
         tmr_q      <= tmr_d;
         mode_q     <= mode_d;
         err_q      <= err_d;
         done_q     <= done_d;
         valid_q    <= emit;
         color_q    <= emit ? bayer_color(out_cnt_q[COLS_LOG2], out_cnt_q[0]) : VOID;
         last_col_q <= emit && &out_cnt_q[COLS_LOG2-1:0];
         last_pic_q <= emit && &out_cnt_q;
         if (emit) pixel_q <= emit_data;
      end
   end

   assign pixel_out    = pixel_q;
   assign valid_out    = valid_q;
   assign color_out    = color_q;
   assign last_col_out = last_col_q;
   assign last_pic_out = last_pic_q;
   assign mode_out     = mode_q;
   assign busy         = state_q != IDLE;
   assign done         = done_q;
   assign timeout_err  = err_q;
endmodule
